// File: rtl/mips_pkg.sv
// Shared fetch-stage types and constants: default widths, NOP encoding and
// the fetch FSM state type.
package mips_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int PC_STEP_DEFAULT = 4;
    localparam logic [XLEN_DEFAULT-1:0] NOP_INST = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave).
interface fetch_stage_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] imemAddr;
    logic            imemReq;
    logic [XLEN-1:0] imemRdata;
    logic            imemReady;

    modport master (
        output imemAddr,
        output imemReq,
        input  imemRdata,
        input  imemReady
    );

    modport slave (
        input  imemAddr,
        input  imemReq,
        output imemRdata,
        output imemReady
    );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: write-enabled load, flush-to-NOP and a valid bit.
// PC+step is only refreshed when a real instruction is loaded.
module if_id_reg
    import mips_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            writeEn,
    input  logic [XLEN-1:0] instD,
    input  logic [XLEN-1:0] pcPlus4D,
    input  logic            validD,
    output logic [XLEN-1:0] instQ,
    output logic [XLEN-1:0] pcPlus4Q,
    output logic            validQ
);

    always_ff @(posedge clk) begin
        if (rst) begin
            instQ    <= XLEN'(NOP_INST);
            pcPlus4Q <= '0;
            validQ   <= 1'b0;
        end else if (flush) begin
            instQ  <= XLEN'(NOP_INST);
            validQ <= 1'b0;
        end else if (writeEn) begin
            instQ  <= instD;
            validQ <= validD;
            if (validD) begin
                pcPlus4Q <= pcPlus4D;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, fetch FSM, one-entry hold buffer and the IF/ID
// register. Optional FETCH_STATS_EN adds saturating stall/bubble counters.
//
// state | meaning
// FETCH | request outstanding at PC; a returned instruction goes to IF/ID
// HOLD  | buffer has an instruction IF/ID has not accepted; no request
module fetch_stage
    import mips_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCWrite,
    input  logic            IfIdWrite,
    input  logic            flush,
    input  logic [XLEN-1:0] branchTarget,
    fetch_stage_if.master   imem,
    output logic [XLEN-1:0] IfIdInst,
    output logic [XLEN-1:0] IfIdPcPlus4,
    output logic            IfIdValid
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]     stallCycles,
    output logic [31:0]     bubbleCycles
`endif
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcPlusStep;
    logic [XLEN-1:0] bufInst;
    logic [XLEN-1:0] bufPcPlus4;
    logic            reqReg;

    logic [XLEN-1:0] loadInst;
    logic [XLEN-1:0] loadPcPlus4;
    logic            loadValid;
    logic            acceptNow;

    assign pcPlusStep    = pc + XLEN'(PC_STEP);
    assign imem.imemAddr = pc;
    assign imem.imemReq  = reqReg;

    // IF/ID accepts an instruction only when it is writable and one is available.
    assign acceptNow = IfIdWrite && ((state == HOLD) || imem.imemReady);

    always_comb begin
        loadInst    = imem.imemRdata;
        loadPcPlus4 = pcPlusStep;
        loadValid   = imem.imemReady;
        if (state == HOLD) begin
            loadInst    = bufInst;
            loadPcPlus4 = bufPcPlus4;
            loadValid   = 1'b1;
        end else if (!imem.imemReady) begin
            loadInst = XLEN'(NOP_INST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            reqReg     <= 1'b1;
            pc         <= RESET_PC;
            bufInst    <= '0;
            bufPcPlus4 <= '0;
        end else if (flush) begin
            state      <= FETCH;
            reqReg     <= 1'b1;
            pc         <= branchTarget;
            bufInst    <= '0;
            bufPcPlus4 <= '0;
        end else begin
            if (acceptNow && PCWrite) begin
                pc <= pcPlusStep;
            end
            case (state)
                FETCH: begin
                    if (imem.imemReady && !IfIdWrite) begin
                        bufInst    <= imem.imemRdata;
                        bufPcPlus4 <= pcPlusStep;
                        state      <= HOLD;
                        reqReg     <= 1'b0;
                    end
                end
                HOLD: begin
                    if (IfIdWrite) begin
                        state  <= FETCH;
                        reqReg <= 1'b1;
                    end
                end
                default: begin
                    state  <= FETCH;
                    reqReg <= 1'b1;
                end
            endcase
        end
    end

    if_id_reg #(
        .XLEN(XLEN)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .writeEn (IfIdWrite),
        .instD   (loadInst),
        .pcPlus4D(loadPcPlus4),
        .validD  (loadValid),
        .instQ   (IfIdInst),
        .pcPlus4Q(IfIdPcPlus4),
        .validQ  (IfIdValid)
    );

`ifdef FETCH_STATS_EN
    logic bubbleNow;

    // A flush counts as a bubble as well: IF/ID loads a NOP with valid=0.
    assign bubbleNow = flush || (IfIdWrite && (state == FETCH) && !imem.imemReady);

    always_ff @(posedge clk) begin
        if (rst) begin
            stallCycles  <= '0;
            bubbleCycles <= '0;
        end else begin
            if (!IfIdWrite && (stallCycles != '1)) begin
                stallCycles <= stallCycles + 32'd1;
            end
            if (bubbleNow && (bubbleCycles != '1)) begin
                bubbleCycles <= bubbleCycles + 32'd1;
            end
        end
    end
`endif

endmodule
